c_rot_rr_sched: RTL and testbench

//  Round-robin scheduler that shares one downstream resource (crossbar port,
//  VC buffer read port, ...) among num_ports requesters with multi-cycle

---
 rtl/c_rot_rr_sched_if.sv | 33 +++
 rtl/c_rot_rr_sched.sv | 122 ++++++++++++
 tb/tb_c_rot_rr_sched.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/c_rot_rr_sched_if.sv
// Requester-side bundle for c_rot_rr_sched: request/release inputs, registered
// grant outputs, and debug taps exposing FSM state, priority pointer and hold count.
interface c_rot_rr_sched_if #(
  parameter int num_ports = 8,
  parameter int max_hold  = 16
);
  localparam int IDX_W  = (num_ports > 1) ? $clog2(num_ports) : 1;
  localparam int HOLD_W = (max_hold > 0) ? $clog2(max_hold + 1) : 1;

  // Handshake: a requester holds req[i] high until it sees gnt[i]; ownership
  // lasts while gnt_valid=1 and ends on the edge after release_gnt=1 (sampled
  // only in OWNED with active=1) or on a forced end flagged by timeout.
  logic                   active;
  logic [0:num_ports-1]   req;
  logic                   release_gnt;
  logic [0:num_ports-1]   gnt;
  logic [IDX_W-1:0]       gnt_idx;
  logic                   gnt_valid;
  logic                   timeout;
  logic                   dbg_state;
  logic [IDX_W-1:0]       dbg_prio_ptr;
  logic [HOLD_W-1:0]      dbg_hold_cnt;

  modport master (
    output active, req, release_gnt,
    input  gnt, gnt_idx, gnt_valid, timeout, dbg_state, dbg_prio_ptr, dbg_hold_cnt
  );

  modport slave (
    input  active, req, release_gnt,
    output gnt, gnt_idx, gnt_valid, timeout, dbg_state, dbg_prio_ptr, dbg_hold_cnt
  );
endinterface

// File: rtl/c_rot_rr_sched.sv
// Round-robin scheduler with multi-cycle ownership: rotating-pointer priority,
// registered one-hot grant held until release or hold timeout.
module c_rot_rr_sched #(
  parameter int num_ports = 8,
  parameter int max_hold  = 16
) (
  input  logic               clk,
  input  logic               reset,
  c_rot_rr_sched_if.slave    bus
);
  localparam int IDX_W  = (num_ports > 1) ? $clog2(num_ports) : 1;
  localparam int HOLD_W = (max_hold > 0) ? $clog2(max_hold + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = (max_hold > 0) ? HOLD_W'(max_hold - 1) : '0;
  localparam logic [IDX_W-1:0]  LAST_PORT = IDX_W'(num_ports - 1);

  typedef enum logic {IDLE = 1'b0, OWNED = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     prio_ptr, ptr_d;
  logic [IDX_W-1:0]     gnt_idx_q, idx_d;
  logic [HOLD_W-1:0]    hold_cnt, hold_d;
  logic [0:num_ports-1] gnt_q, gnt_d;
  logic                 valid_q, valid_d;
  logic                 timeout_q, timeout_d;

  logic                 hold_expired;
  logic                 end_grant;
  logic [IDX_W-1:0]     next_ptr;
  logic [IDX_W-1:0]     sel_ptr;
  logic                 found;
  logic [IDX_W-1:0]     win;
  int                   cand;

  // On a grant end the search already uses the post-release pointer, so the
  // next owner is granted on the same edge with no idle bubble.
  always_comb begin
    hold_expired = (max_hold > 0) && (hold_cnt == HOLD_LAST);
    end_grant    = (state_q == OWNED) && (bus.release_gnt || hold_expired);
    next_ptr     = (gnt_idx_q == LAST_PORT) ? '0 : gnt_idx_q + IDX_W'(1);
    sel_ptr      = end_grant ? next_ptr : prio_ptr;
    found        = 1'b0;
    win          = '0;
    cand         = 0;
    for (int k = 0; k < num_ports; k++) begin
      cand = int'(sel_ptr) + k;
      if (cand >= num_ports) cand = cand - num_ports;
      if (!found && bus.req[IDX_W'(cand)]) begin
        found = 1'b1;
        win   = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = prio_ptr;
    idx_d     = gnt_idx_q;
    hold_d    = hold_cnt;
    gnt_d     = gnt_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d    = OWNED;
          idx_d      = win;
          gnt_d      = '0;
          gnt_d[win] = 1'b1;
          valid_d    = 1'b1;
          hold_d     = '0;
        end
      end
      OWNED: begin
        if (end_grant) begin
          ptr_d     = next_ptr;
          timeout_d = !bus.release_gnt;
          hold_d    = '0;
          if (found) begin
            idx_d      = win;
            gnt_d      = '0;
            gnt_d[win] = 1'b1;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            valid_d = 1'b0;
          end
        end else if (hold_cnt != '1) begin
          hold_d = hold_cnt + HOLD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      prio_ptr  <= '0;
      gnt_idx_q <= '0;
      hold_cnt  <= '0;
      gnt_q     <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else if (bus.active) begin
      state_q   <= state_d;
      prio_ptr  <= ptr_d;
      gnt_idx_q <= idx_d;
      hold_cnt  <= hold_d;
      gnt_q     <= gnt_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.gnt          = gnt_q;
  assign bus.gnt_idx      = gnt_idx_q;
  assign bus.gnt_valid    = valid_q;
  assign bus.timeout      = timeout_q;
  assign bus.dbg_state    = (state_q == OWNED);
  assign bus.dbg_prio_ptr = prio_ptr;
  assign bus.dbg_hold_cnt = hold_cnt;
endmodule

// File: tb/tb_c_rot_rr_sched.sv
// Bench for c_rot_rr_sched: two instances (8 ports/max_hold 4, 5 ports/unlimited)
// checked every cycle against an ownership-level model plus literal expectations.
module tb_c_rot_rr_sched;
  logic clk;
  logic rst;

  c_rot_rr_sched_if #(.num_ports(8), .max_hold(4)) a_if ();
  c_rot_rr_sched_if #(.num_ports(5), .max_hold(0)) b_if ();

  c_rot_rr_sched #(.num_ports(8), .max_hold(4)) u_a (.clk(clk), .reset(rst), .bus(a_if));
  c_rot_rr_sched #(.num_ports(5), .max_hold(0)) u_b (.clk(clk), .reset(rst), .bus(b_if));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // model state, index 0 = instance a, 1 = instance b
  int nports[2] = '{8, 5};
  int mhold[2]  = '{4, 0};
  int m_owner[2] = '{0, 0};
  int m_idx[2]   = '{0, 0};
  int m_ptr[2]   = '{0, 0};
  int m_age[2]   = '{0, 0};
  bit m_owned[2] = '{0, 0};
  bit m_to[2]    = '{0, 0};
  int mask_a = 0, mask_b = 0;

  task automatic chk(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(int n, int mask, int p);
    for (int k = 0; k < n; k++) begin
      if (mask[(p + k) % n]) return (p + k) % n;
    end
    return -1;
  endfunction

  task automatic model_step(int u, int mask, bit rel, bit act);
    int w;
    if (!act) return;
    if (!m_owned[u]) begin
      m_to[u] = 1'b0;
      w = pick(nports[u], mask, m_ptr[u]);
      if (w >= 0) begin
        m_owned[u] = 1'b1; m_owner[u] = w; m_idx[u] = w; m_age[u] = 0;
      end
    end else if (rel || (mhold[u] > 0 && m_age[u] == mhold[u] - 1)) begin
      m_to[u]  = !rel;
      m_ptr[u] = (m_owner[u] + 1) % nports[u];
      w = pick(nports[u], mask, m_ptr[u]);
      m_age[u] = 0;
      if (w >= 0) begin
        m_owner[u] = w; m_idx[u] = w;
      end else begin
        m_owned[u] = 1'b0;
      end
    end else begin
      m_to[u] = 1'b0;
      m_age[u]++;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int u = 0; u < 2; u++) begin
        m_owner[u] = 0; m_idx[u] = 0; m_ptr[u] = 0; m_age[u] = 0;
        m_owned[u] = 1'b0; m_to[u] = 1'b0;
      end
    end else begin
      model_step(0, mask_a, a_if.release_gnt, a_if.active);
      model_step(1, mask_b, b_if.release_gnt, b_if.active);
    end
  end

  // scoreboard: compare every cycle on the inactive edge
  always @(negedge clk) begin
    int ga, gb;
    ga = 0; gb = 0;
    for (int i = 0; i < 8; i++) if (a_if.gnt[i]) ga |= (1 << i);
    for (int i = 0; i < 5; i++) if (b_if.gnt[i]) gb |= (1 << i);
    chk("a_gnt",     ga, m_owned[0] ? (1 << m_owner[0]) : 0);
    chk("a_gnt_idx", int'(a_if.gnt_idx), m_idx[0]);
    chk("a_valid",   int'(a_if.gnt_valid), int'(m_owned[0]));
    chk("a_state",   int'(a_if.dbg_state), int'(m_owned[0]));
    chk("a_timeout", int'(a_if.timeout), int'(m_to[0]));
    chk("a_ptr",     int'(a_if.dbg_prio_ptr), m_ptr[0]);
    chk("a_hold",    int'(a_if.dbg_hold_cnt), m_age[0]);
    chk("b_gnt",     gb, m_owned[1] ? (1 << m_owner[1]) : 0);
    chk("b_gnt_idx", int'(b_if.gnt_idx), m_idx[1]);
    chk("b_valid",   int'(b_if.gnt_valid), int'(m_owned[1]));
    chk("b_timeout", int'(b_if.timeout), int'(m_to[1]));
    chk("b_ptr",     int'(b_if.dbg_prio_ptr), m_ptr[1]);
  end

  // driver tasks
  task automatic set_a(int mask, bit rel, bit act);
    mask_a = mask;
    for (int i = 0; i < 8; i++) a_if.req[i] = mask[i];
    a_if.release_gnt = rel;
    a_if.active = act;
  endtask

  task automatic set_b(int mask, bit rel, bit act);
    mask_b = mask;
    for (int i = 0; i < 5; i++) b_if.req[i] = mask[i];
    b_if.release_gnt = rel;
    b_if.active = act;
  endtask

  task automatic step(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    set_a(0, 1'b0, 1'b1);
    set_b(0, 1'b0, 1'b1);
    step(2);
    chk("lit_reset_valid", int'(a_if.gnt_valid), 0);
    rst = 1'b0;

    // ports 2 and 5 requesting from pointer 0, then release -> 5, pointer 3
    set_a(32'h24, 1'b0, 1'b1);
    step();
    chk("lit_t1_first", int'(a_if.gnt_idx), 2);
    set_a(32'h24, 1'b1, 1'b1);
    step();
    chk("lit_t1_second", int'(a_if.gnt_idx), 5);
    chk("lit_t1_ptr", int'(a_if.dbg_prio_ptr), 3);

    // wrap from pointer 6 to port 1, then port 3
    set_a(32'h0A, 1'b1, 1'b1);
    step();
    chk("lit_t2_wrap", int'(a_if.gnt_idx), 1);
    chk("lit_t2_ptr", int'(a_if.dbg_prio_ptr), 6);
    step();
    chk("lit_t2_next", int'(a_if.gnt_idx), 3);
    set_a(0, 1'b1, 1'b1);
    step();
    chk("lit_idle_valid", int'(a_if.gnt_valid), 0);
    chk("lit_idle_idx", int'(a_if.gnt_idx), 3);

    // hold timeout with a lone constant requester
    set_a(32'h01, 1'b0, 1'b1);
    step();
    chk("lit_t3_idx", int'(a_if.gnt_idx), 0);
    step(3);
    chk("lit_t3_hold3", int'(a_if.dbg_hold_cnt), 3);
    chk("lit_t3_no_to", int'(a_if.timeout), 0);
    step();
    chk("lit_t3_timeout", int'(a_if.timeout), 1);
    chk("lit_t3_regrant", int'(a_if.gnt_valid), 1);
    chk("lit_t3_ptr", int'(a_if.dbg_prio_ptr), 1);
    step();
    chk("lit_t3_pulse_end", int'(a_if.timeout), 0);

    // active=0 freezes everything, even with release asserted
    set_a(32'h41, 1'b1, 1'b0);
    step(2);
    chk("lit_t4_idx", int'(a_if.gnt_idx), 0);
    chk("lit_t4_hold", int'(a_if.dbg_hold_cnt), 1);
    chk("lit_t4_to", int'(a_if.timeout), 0);
    set_a(32'h41, 1'b1, 1'b1);
    step();
    chk("lit_t4_resume", int'(a_if.gnt_idx), 6);
    set_a(32'h41, 1'b0, 1'b1);
    step();

    // asynchronous reset between edges
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("lit_t5_gnt", (a_if.gnt == '0) ? 0 : 1, 0);
    chk("lit_t5_valid", int'(a_if.gnt_valid), 0);
    chk("lit_t5_to", int'(a_if.timeout), 0);
    step();
    rst = 1'b0;
    set_a(32'h10, 1'b0, 1'b1);
    step();
    chk("lit_t5_after", int'(a_if.gnt_idx), 4);
    set_a(0, 1'b1, 1'b1);
    step();
    set_a(0, 1'b0, 1'b1);

    // five ports, unlimited hold
    set_b(32'h10, 1'b0, 1'b1);
    step(20);
    chk("lit_t6_held", int'(b_if.gnt_idx), 4);
    chk("lit_t6_no_to", int'(b_if.timeout), 0);
    set_b(32'h11, 1'b1, 1'b1);
    step();
    chk("lit_t6_wrap", int'(b_if.gnt_idx), 0);
    chk("lit_t6_ptr", int'(b_if.dbg_prio_ptr), 0);
    set_b(0, 1'b1, 1'b1);
    step(2);
    chk("lit_t6_idle", int'(b_if.gnt_valid), 0);
    set_b(32'h01, 1'b0, 1'b1);
    step();
    set_b(32'h01, 1'b1, 1'b1);
    step();
    chk("lit_t6_sole", int'(b_if.gnt_idx), 0);
    chk("lit_t6_sole_v", int'(b_if.gnt_valid), 1);
    set_b(0, 1'b0, 1'b1);
    step(2);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
